fetch_prefetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the decode/controller stage.
- Owns the program counter and issues word reads to the synchronous byte-addressed instruction memory (1-cycle read latency, big-endian word = {mem[a],mem[a+1],mem[a+2],mem[a+3]}).
- Buffers returned instructions in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch/jump/jr redirects, which flush all prefetched and in-flight work.

---
 rtl/mips_pkg.sv | 14 +
 rtl/prefetch_fifo.sv | 57 +++++
 rtl/fetch_prefetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: instruction width, default PC width, fetch FSM states, NOP word.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;
    localparam int INSTR_W  = 32;
    localparam int DEF_PC_W = 7;
    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/prefetch_fifo.sv
// Generic DEPTH x W synchronous FIFO with push/pop/flush; head is a registered-array read.
// Latency: a push is visible at the head on the edge after it is written (no bypass).
// Backpressure: push while full and pop while empty are ignored; flush wins over push/pop.
// Ports: clk, rst (sync active-high); i_push/i_push_dat, i_pop, i_flush;
//        o_head_dat, o_count (log2(DEPTH)+1 bits), o_full, o_empty.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 39,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    input  logic          i_flush,
    output logic [W-1:0]  o_head_dat,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_empty
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is only meaningful when not empty.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch: owns the PC, reads 1-cycle imem, buffers words in a prefetch FIFO for decode.
// Latency: first instruction visible 2 cycles after reset/redirect (issue, return, FIFO head).
// Backpressure: id_valid/id_ready; issue only while FIFO count + in-flight < DEPTH.
// Ports: clk, rst (sync active-high); imem_rd_en/imem_addr/imem_rdata; id_valid/id_ready/
//        id_instr/id_pc/id_pc4; redirect_valid/redirect_pc; halted; misalign_err.
// Optional: FETCH_PERF_EN adds saturating perf_stall_cycles, perf_flushes, perf_fetched.
module fetch_prefetch_unit
    import mips_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [PC_W-1:0] HALT_PC  = 7'h7C
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc4,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               halted,
    output logic               misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [15:0]        perf_flushes,
    output logic [31:0]        perf_fetched
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = PC_W + INSTR_W;

    fetch_state_e     r_state;
    fetch_state_e     w_state_nxt;
    logic [PC_W-1:0]  r_fetch_pc;
    logic [PC_W-1:0]  r_inflight_pc;
    logic             r_inflight;
    logic             r_misalign;
    logic             w_issue;
    logic             w_credit_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [AW:0]      w_count;
    logic [FW-1:0]    w_head;
    logic [PC_W-1:0]  w_head_pc;

    // Count without the same-cycle pop: conservative, but still sustains one word per cycle.
    assign w_credit_ok = (32'(w_count) + 32'(r_inflight)) < 32'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (r_fetch_pc == HALT_PC) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty && !r_inflight) w_state_nxt = ST_HALT;
            end
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_RUN;
        endcase
        // A redirect restarts fetch next cycle; nothing is issued from the stale PC.
        if (redirect_valid) begin
            w_issue     = 1'b0;
            w_state_nxt = ST_RUN;
        end
        if (rst) w_issue = 1'b0;
    end

    // Clearing r_inflight on redirect is what kills the outstanding return.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_misalign    <= 1'b0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[PC_W-1:2], 2'b00};
            r_inflight <= 1'b0;
            if (|redirect_pc[1:0]) r_misalign <= 1'b1;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + PC_W'(4);
            end
        end
    end

    assign w_push = r_inflight && !w_full;
    assign w_pop  = id_valid && id_ready && !redirect_valid;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat ({r_inflight_pc, imem_rdata}),
        .i_pop      (w_pop),
        .i_flush    (redirect_valid),
        .o_head_dat (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_head_pc    = w_head[FW-1 -: PC_W];
    assign id_valid     = !w_empty;
    assign id_instr     = w_empty ? NOP_WORD : w_head[INSTR_W-1:0];
    assign id_pc        = w_empty ? '0 : w_head_pc;
    assign id_pc4       = w_empty ? '0 : (w_head_pc + PC_W'(4));
    assign imem_rd_en   = w_issue;
    assign imem_addr    = r_fetch_pc;
    assign halted       = (r_state == ST_HALT);
    assign misalign_err = r_misalign;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_flush;
    logic [31:0] r_perf_fetch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_fetch <= '0;
        end else begin
            if (id_ready && !id_valid && !halted && !(&r_perf_stall))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (redirect_valid && !(&r_perf_flush))
                r_perf_flush <= r_perf_flush + 16'd1;
            if (w_pop && !(&r_perf_fetch))
                r_perf_fetch <= r_perf_fetch + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flushes      = r_perf_flush;
    assign perf_fetched      = r_perf_fetch;
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: byte memory model, in-order acceptance monitor, scenario checks.
// Latency: n/a.
// Backpressure: drives id_ready low to exercise credit stall and full-FIFO reset.
module tb_fetch_prefetch_unit;
    localparam int PC_W = 7;

    logic            clk;
    logic            rst;
    logic            imem_rd_en;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [31:0]     id_instr;
    logic [PC_W-1:0] id_pc;
    logic [PC_W-1:0] id_pc4;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            halted;
    logic            misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_stall_cycles;
    logic [15:0]     perf_flushes;
    logic [31:0]     perf_fetched;
`endif

    fetch_prefetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
        .misalign_err   (misalign_err)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flushes      (perf_flushes),
        .perf_fetched      (perf_fetched)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_issue  = 0;
    int n_acc    = 0;
    int n_7c     = 0;
    logic [PC_W-1:0] exp_pc;
    logic [PC_W-1:0] mon_pc4;
    logic [7:0]      mem [128];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Test words at 0..15, then an address-tagged pattern everywhere else.
    function automatic logic [31:0] exp_word(input logic [PC_W-1:0] a);
        logic [31:0] tbl [4];
        tbl[0] = 32'h00221820;
        tbl[1] = 32'h8C220000;
        tbl[2] = 32'hAC220004;
        tbl[3] = 32'h00000000;
        if (a < 7'd16) return tbl[a[3:2]];
        return {16'hC0DE, 9'd0, a};
    endfunction

    initial begin
        logic [31:0] w;
        for (int a = 0; a < 128; a += 4) begin
            w = exp_word(7'(a));
            {mem[a], mem[a+1], mem[a+2], mem[a+3]} = w;
        end
    end

    always @(posedge clk) begin
        if (imem_rd_en)
            imem_rdata <= {mem[imem_addr], mem[imem_addr + 7'd1],
                           mem[imem_addr + 7'd2], mem[imem_addr + 7'd3]};
    end

    // Expected stream: restart at 0 on reset, at the aligned target on redirect, else +4 per accept.
    always @(negedge clk) begin
        if (rst) begin
            exp_pc = '0;
        end else begin
            if (imem_rd_en) n_issue++;
            if (redirect_valid) begin
                exp_pc = {redirect_pc[PC_W-1:2], 2'b00};
            end else if (id_valid && id_ready) begin
                mon_pc4 = exp_pc + 7'd4;
                chk("acc_pc", 64'(id_pc), 64'(exp_pc));
                chk("acc_instr", 64'(id_instr), 64'(exp_word(exp_pc)));
                chk("acc_pc4", 64'(id_pc4), 64'(mon_pc4));
                if (id_pc == 7'h7C) n_7c++;
                exp_pc = mon_pc4;
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input int budget, input string tag);
        int k = 0;
        while (n_acc < target && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 64'(n_acc >= target), 64'd1);
    endtask

    initial begin
        logic prev_rd;
        int   k;
        int   iss;
        rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state
        repeat (2) tick();
        @(negedge clk);
        chk("rst_rd_en", 64'(imem_rd_en), 64'd0);
        chk("rst_valid", 64'(id_valid), 64'd0);
        chk("rst_instr", 64'(id_instr), 64'd0);
        chk("rst_pc", 64'(id_pc), 64'd0);
        chk("rst_pc4", 64'(id_pc4), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_misalign", 64'(misalign_err), 64'd0);

        // First-instruction latency and fill
        tick(); rst = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        chk("first_rd_en", 64'(imem_rd_en), 64'd1);
        chk("first_addr", 64'(imem_addr), 64'd0);
        tick(); @(negedge clk);
        chk("lat1_valid", 64'(id_valid), 64'd0);
        tick(); @(negedge clk);
        chk("lat2_valid", 64'(id_valid), 64'd1);
        chk("lat2_pc", 64'(id_pc), 64'd0);
`ifdef FETCH_PERF_EN
        chk("perf_stall_start", 64'(perf_stall_cycles), 64'd2);
`endif
        wait_acc(4, 20, "fill_wait");

        // Credit stall: head must hold at 0x10, exactly DEPTH outstanding
        id_ready = 1'b0;
        @(negedge clk);
        chk("stall_head_pc", 64'(id_pc), 64'h10);
        repeat (10) tick();
        @(negedge clk);
        chk("stall_rd_en", 64'(imem_rd_en), 64'd0);
        chk("stall_head_pc2", 64'(id_pc), 64'h10);
        chk("stall_head_instr", 64'(id_instr), 64'(exp_word(7'h10)));
        chk("stall_buffered", 64'(n_issue - n_acc), 64'd4);
        tick(); id_ready = 1'b1;
        wait_acc(9, 30, "release_wait");

        // Redirect with 3 buffered + 1 in flight
        id_ready = 1'b0;
        @(negedge clk);
        prev_rd = imem_rd_en;
        tick(); redirect_valid = 1'b1; redirect_pc = 7'h40;
        @(negedge clk);
        chk("redir_prev_issue", 64'(prev_rd), 64'd1);
        chk("redir_outstanding", 64'(n_issue - n_acc), 64'd4);
        chk("redir_no_issue", 64'(imem_rd_en), 64'd0);
        tick(); redirect_valid = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        chk("redir_flushed", 64'(id_valid), 64'd0);
        chk("redir_fetch_addr", 64'(imem_addr), 64'h40);
        wait_acc(n_acc + 3, 20, "redir_wait");

        // Run to HALT_PC
        k = 0;
        while (!halted && k < 100) begin tick(); k++; end
        @(negedge clk);
        chk("halted", 64'(halted), 64'd1);
        chk("halt_7c_once", 64'(n_7c), 64'd1);
        iss = n_issue;
        repeat (5) tick();
        @(negedge clk);
        chk("halt_rd_en", 64'(imem_rd_en), 64'd0);
        chk("halt_no_issue", 64'(n_issue), 64'(iss));
        chk("halt_valid", 64'(id_valid), 64'd0);
        chk("halt_7c_still_once", 64'(n_7c), 64'd1);
`ifdef FETCH_PERF_EN
        chk("perf_flushes", 64'(perf_flushes), 64'd1);
        chk("perf_fetched", 64'(perf_fetched), 64'(n_acc));
`endif

        // Redirect out of HALT
        tick(); redirect_valid = 1'b1; redirect_pc = 7'h10;
        @(negedge clk);
        chk("halt_hold_redir", 64'(halted), 64'd1);
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("halt_cleared", 64'(halted), 64'd0);
        wait_acc(n_acc + 2, 20, "resume_wait");

        // Misaligned redirect
        chk("misalign_pre", 64'(misalign_err), 64'd0);
        tick(); redirect_valid = 1'b1; redirect_pc = 7'h13;
        tick(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("misalign_set", 64'(misalign_err), 64'd1);
        chk("misalign_fetch_addr", 64'(imem_addr), 64'h10);
        wait_acc(n_acc + 3, 20, "misalign_wait");
        chk("misalign_sticky", 64'(misalign_err), 64'd1);

        // Reset mid-stream with a full FIFO
        id_ready = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("full_valid", 64'(id_valid), 64'd1);
        chk("full_rd_en", 64'(imem_rd_en), 64'd0);
        tick(); rst = 1'b1;
        tick(); rst = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 64'(id_valid), 64'd0);
        chk("mrst_halted", 64'(halted), 64'd0);
        chk("mrst_misalign", 64'(misalign_err), 64'd0);
        chk("mrst_rd_en", 64'(imem_rd_en), 64'd1);
        chk("mrst_addr", 64'(imem_addr), 64'd0);
`ifdef FETCH_PERF_EN
        chk("mrst_perf_stall", 64'(perf_stall_cycles), 64'd0);
        chk("mrst_perf_flush", 64'(perf_flushes), 64'd0);
        chk("mrst_perf_fetch", 64'(perf_fetched), 64'd0);
`endif
        wait_acc(n_acc + 3, 20, "restart_wait");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
